// File: rtl/uart_fifo_tx.sv
// Buffered UART transmitter: a word FIFO feeding a start/data/parity/stop framer.
// Ports: clk_i, rst_n, wr_en_i/wr_data_i in; full/empty/level/overflow, busy, msg_done, tx out.
module uart_fifo_tx #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int NULL_TERM    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [DATA_BITS-1:0]   wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   busy_o,
  output logic                   msg_done_o,
  output logic                   tx_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr_ok;
  logic                 rd_en;
  logic [LW-1:0]        level_n;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DW-1:0]        div;
  logic [BW-1:0]        bit_cnt;
  logic                 bit_end;

  // full_o is the registered flag, so a write in a popping cycle still drops
  assign wr_ok   = wr_en_i && !full_o;
  assign rd_en   = (state == S_LOAD);
  assign level_n = level_o + LW'(wr_ok) - LW'(rd_en);
  assign head    = mem[rd_ptr];
  assign bit_end = (div == DW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      full_o     <= 1'b0;
      empty_o    <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level_o <= level_n;
      full_o  <= (level_n == LW'(DEPTH));
      empty_o <= (level_n == '0);
      if (wr_en_i && full_o) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      msg_done_o <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      div        <= '0;
      bit_cnt    <= '0;
    end else begin
      msg_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_o <= 1'b1;
          if (!empty_o) begin
            state  <= S_LOAD;
            busy_o <= 1'b1;
          end
        end
        S_LOAD: begin
          shreg   <= head;
          par_bit <= (^head) ^ (PARITY == 1);
          div     <= '0;
          bit_cnt <= '0;
          if (NULL_TERM != 0 && head == '0) begin
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            msg_done_o <= 1'b1;
          end else begin
            state <= S_START;
            tx_o  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            div   <= '0;
            state <= S_DATA;
            tx_o  <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
            div <= div + DW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div <= '0;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx_o  <= par_bit;
              end else begin
                state <= S_STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        S_PAR: begin
          if (bit_end) begin
            div   <= '0;
            state <= S_STOP;
            tx_o  <= 1'b1;
          end else begin
            div <= div + DW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            div <= '0;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              if (!empty_o) begin
                state <= S_LOAD;
              end else begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
